// File: rtl/buffer_id_ex_hz_pkg.sv
// Shared constants for the ID/EX pipeline register: control-bundle field
// positions, bundle widths and the per-edge stage action.
package buffer_id_ex_hz_pkg;

   localparam int DATA_W_DEF  = 32;
   localparam int REG_W_DEF   = 5;
   localparam int JADDR_W_DEF = 26;
   localparam int ALUOP_W_DEF = 4;
   localparam int CNT_W_DEF   = 16;

   localparam int EX_W = ALUOP_W_DEF + 2;
   localparam int M_W  = 4;
   localparam int WB_W = 2;

   localparam int M_BRANCH    = 0;
   localparam int M_MEMREAD   = 1;
   localparam int M_MEMWRITE  = 2;
   localparam int M_JUMP      = 3;
   localparam int WB_REGWRITE = 0;
   localparam int WB_MEMTOREG = 1;
   localparam int EX_REGDST   = 0;

   typedef enum logic [1:0] {
      ACT_LOAD   = 2'd0,
      ACT_BUBBLE = 2'd1,
      ACT_HOLD   = 2'd2
   } stage_act_e;

   // A downstream stall outranks any request to kill the incoming instruction.
   function automatic stage_act_e select_act(input logic stall, input logic kill);
      stage_act_e act;
      if (stall) begin
         act = ACT_HOLD;
      end else if (kill) begin
         act = ACT_BUBBLE;
      end else begin
         act = ACT_LOAD;
      end
      return act;
   endfunction

endpackage

// File: rtl/buffer_id_ex_hz_if.sv
// ID-side instruction bundle in, registered EX-side bundle out.
interface buffer_id_ex_hz_if #(
   parameter int DATA_W  = 32,
   parameter int REG_W   = 5,
   parameter int JADDR_W = 26,
   parameter int ALUOP_W = 4
) ();

   logic [DATA_W-1:0]  add1, rd1, rd2, signext;
   logic [REG_W-1:0]   inst25_21, inst20_16, inst15_11;
   logic [JADDR_W-1:0] inst25_0;
   logic               RegWrite, MemtoReg, Branch, MemRead, MemWrite, Reg_Dst, Alu_Src, Jump;
   logic [ALUOP_W-1:0] Alu_Op;

   logic [ALUOP_W+1:0] EX;
   logic [3:0]         M;
   logic [1:0]         WB;
   logic               valid_o;
   logic [DATA_W-1:0]  salidAdd1, salidard1, salidard2, salidasignext;
   logic [REG_W-1:0]   salidainst20_16, salidainst15_11;
   logic [JADDR_W-1:0] salidainst25_0;

   modport slave (
      input  add1, rd1, rd2, signext, inst25_21, inst20_16, inst15_11, inst25_0,
             RegWrite, MemtoReg, Branch, MemRead, MemWrite, Reg_Dst, Alu_Src, Jump, Alu_Op,
      output EX, M, WB, valid_o, salidAdd1, salidard1, salidard2, salidasignext,
             salidainst20_16, salidainst15_11, salidainst25_0
   );

   modport master (
      output add1, rd1, rd2, signext, inst25_21, inst20_16, inst15_11, inst25_0,
             RegWrite, MemtoReg, Branch, MemRead, MemWrite, Reg_Dst, Alu_Src, Jump, Alu_Op,
      input  EX, M, WB, valid_o, salidAdd1, salidard1, salidard2, salidasignext,
             salidainst20_16, salidainst15_11, salidainst25_0
   );

endinterface

// File: rtl/buffer_id_ex_hz_hazard_load_use.sv
// Load-use detector: a valid load in EX whose non-zero destination (rt)
// is read by the instruction currently in ID.
module hazard_load_use #(
   parameter int REG_W = 5
) (
   input  logic             ex_valid_i,
   input  logic             ex_memread_i,
   input  logic [REG_W-1:0] ex_rt_i,
   input  logic [REG_W-1:0] id_rs_i,
   input  logic [REG_W-1:0] id_rt_i,
   output logic             hazard_o
);

   logic rt_nonzero_s;
   logic rt_match_s;

   assign rt_nonzero_s = (ex_rt_i != {REG_W{1'b0}});
   assign rt_match_s   = (ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i);
   assign hazard_o     = ex_valid_i & ex_memread_i & rt_nonzero_s & rt_match_s;

endmodule

// File: rtl/buffer_id_ex_hz.sv
// ID/EX pipeline register with valid bit, hold, flush, load-use bubble
// insertion and a saturating count of inserted bubbles.
module buffer_id_ex_hz
   import buffer_id_ex_hz_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int REG_W   = REG_W_DEF,
   parameter int JADDR_W = JADDR_W_DEF,
   parameter int ALUOP_W = ALUOP_W_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall_i,
   input  logic                 flush_i,
   buffer_id_ex_hz_if.slave     bus,
   output logic                 hazard_o,
   output logic                 stall_o,
   output logic [CNT_W-1:0]     bubble_cnt_o
);

   localparam int EXW = ALUOP_W + 2;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [EXW-1:0]     ex_q, ex_d;
   logic [M_W-1:0]     m_q, m_d;
   logic [WB_W-1:0]    wb_q, wb_d;
   logic               valid_q, valid_d;
   logic [DATA_W-1:0]  add1_q, add1_d, rd1_q, rd1_d, rd2_q, rd2_d, sext_q, sext_d;
   logic [REG_W-1:0]   rt_q, rt_d, rd_q, rd_d;
   logic [JADDR_W-1:0] jaddr_q, jaddr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               hazard_s;
   stage_act_e         act_s;

   hazard_load_use #(.REG_W(REG_W)) u_hazard (
      .ex_valid_i   (valid_q),
      .ex_memread_i (m_q[M_MEMREAD]),
      .ex_rt_i      (rt_q),
      .id_rs_i      (bus.inst25_21),
      .id_rt_i      (bus.inst20_16),
      .hazard_o     (hazard_s)
   );

   assign act_s    = select_act(stall_i, flush_i | hazard_s);
   assign hazard_o = hazard_s;
   assign stall_o  = hazard_s | stall_i;

   // Next-state selection: hold, bubble (controls cleared, data kept) or load.
   always_comb begin
      ex_d    = ex_q;
      m_d     = m_q;
      wb_d    = wb_q;
      valid_d = valid_q;
      add1_d  = add1_q;
      rd1_d   = rd1_q;
      rd2_d   = rd2_q;
      sext_d  = sext_q;
      rt_d    = rt_q;
      rd_d    = rd_q;
      jaddr_d = jaddr_q;
      cnt_d   = cnt_q;
      case (act_s)
         ACT_HOLD: begin
            cnt_d = cnt_q;
         end
         ACT_BUBBLE: begin
            ex_d    = {EXW{1'b0}};
            m_d     = {M_W{1'b0}};
            wb_d    = {WB_W{1'b0}};
            valid_d = 1'b0;
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_ONE;
            end else begin
               cnt_d = cnt_q;
            end
         end
         ACT_LOAD: begin
            ex_d    = {bus.Alu_Src, bus.Alu_Op, bus.Reg_Dst};
            m_d     = {bus.Jump, bus.MemWrite, bus.MemRead, bus.Branch};
            wb_d    = {bus.MemtoReg, bus.RegWrite};
            valid_d = 1'b1;
            add1_d  = bus.add1;
            rd1_d   = bus.rd1;
            rd2_d   = bus.rd2;
            sext_d  = bus.signext;
            rt_d    = bus.inst20_16;
            rd_d    = bus.inst15_11;
            jaddr_d = bus.inst25_0;
         end
         default: begin
            valid_d = valid_q;
         end
      endcase
   end

   // Stage register with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q    <= {EXW{1'b0}};
         m_q     <= {M_W{1'b0}};
         wb_q    <= {WB_W{1'b0}};
         valid_q <= 1'b0;
         add1_q  <= {DATA_W{1'b0}};
         rd1_q   <= {DATA_W{1'b0}};
         rd2_q   <= {DATA_W{1'b0}};
         sext_q  <= {DATA_W{1'b0}};
         rt_q    <= {REG_W{1'b0}};
         rd_q    <= {REG_W{1'b0}};
         jaddr_q <= {JADDR_W{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         ex_q    <= ex_d;
         m_q     <= m_d;
         wb_q    <= wb_d;
         valid_q <= valid_d;
         add1_q  <= add1_d;
         rd1_q   <= rd1_d;
         rd2_q   <= rd2_d;
         sext_q  <= sext_d;
         rt_q    <= rt_d;
         rd_q    <= rd_d;
         jaddr_q <= jaddr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.EX              = ex_q;
   assign bus.M               = m_q;
   assign bus.WB              = wb_q;
   assign bus.valid_o         = valid_q;
   assign bus.salidAdd1       = add1_q;
   assign bus.salidard1       = rd1_q;
   assign bus.salidard2       = rd2_q;
   assign bus.salidasignext   = sext_q;
   assign bus.salidainst20_16 = rt_q;
   assign bus.salidainst15_11 = rd_q;
   assign bus.salidainst25_0  = jaddr_q;
   assign bubble_cnt_o        = cnt_q;

endmodule

// File: tb/tb_buffer_id_ex_hz.sv
// Self-checking bench for buffer_id_ex_hz: directed vector table, reset and
// saturation sequences, then random traffic against a stage-level model.
module tb_buffer_id_ex_hz;

   logic clk = 1'b0;
   logic rst;
   logic stall_i, flush_i, hazard_o, stall_o;
   logic [15:0] bubble_cnt_o;
   logic stall2_i, flush2_i, hazard2_o, stall2_o;
   logic [1:0] bubble_cnt2_o;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   buffer_id_ex_hz_if #(.DATA_W(32), .REG_W(5), .JADDR_W(26), .ALUOP_W(4)) bus ();
   buffer_id_ex_hz_if #(.DATA_W(32), .REG_W(5), .JADDR_W(26), .ALUOP_W(4)) bus2 ();

   buffer_id_ex_hz #(.DATA_W(32), .REG_W(5), .JADDR_W(26), .ALUOP_W(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .bus(bus),
      .hazard_o(hazard_o), .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o));

   buffer_id_ex_hz #(.DATA_W(32), .REG_W(5), .JADDR_W(26), .ALUOP_W(4), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .stall_i(stall2_i), .flush_i(flush2_i), .bus(bus2),
      .hazard_o(hazard2_o), .stall_o(stall2_o), .bubble_cnt_o(bubble_cnt2_o));

   typedef struct {
      logic valid, regwrite, memtoreg, branch, memread, memwrite, regdst, alusrc, jump;
      logic [3:0]  aluop;
      logic [31:0] add1, rd1, rd2, sext;
      logic [4:0]  rt, rd;
      logic [25:0] jaddr;
   } stage_t;

   typedef struct {
      logic stall, flush, lw;
      logic [4:0] rs, rt;
      logic [31:0] add1;
      logic exp_haz, exp_valid;
      logic [3:0] exp_m;
      logic [1:0] exp_wb;
      logic [5:0] exp_ex;
      logic [15:0] exp_cnt;
      logic [31:0] exp_add1;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic st, input logic fl, input logic lw,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] a1,
                               input logic eh, input logic ev, input logic [3:0] em,
                               input logic [1:0] ewb, input logic [5:0] eex,
                               input logic [15:0] ec, input logic [31:0] ea);
      vec_t v;
      v.stall = st; v.flush = fl; v.lw = lw; v.rs = rs; v.rt = rt; v.add1 = a1;
      v.exp_haz = eh; v.exp_valid = ev; v.exp_m = em; v.exp_wb = ewb; v.exp_ex = eex;
      v.exp_cnt = ec; v.exp_add1 = ea;
      return v;
   endfunction

   task automatic clear_inputs();
      bus.add1 = 32'h0; bus.rd1 = 32'h0; bus.rd2 = 32'h0; bus.signext = 32'h0;
      bus.inst25_21 = 5'd0; bus.inst20_16 = 5'd0; bus.inst15_11 = 5'd0; bus.inst25_0 = 26'h0;
      bus.RegWrite = 1'b0; bus.MemtoReg = 1'b0; bus.Branch = 1'b0; bus.MemRead = 1'b0;
      bus.MemWrite = 1'b0; bus.Reg_Dst = 1'b0; bus.Alu_Src = 1'b0; bus.Jump = 1'b0;
      bus.Alu_Op = 4'd0;
      stall_i = 1'b0; flush_i = 1'b0;
   endtask

   // Model of the stage: what instruction sits in EX and how many bubbles so far.
   stage_t m;
   int mcnt;

   function automatic stage_t id_snapshot();
      stage_t s;
      s.valid = 1'b1;
      s.regwrite = bus.RegWrite; s.memtoreg = bus.MemtoReg; s.branch = bus.Branch;
      s.memread = bus.MemRead; s.memwrite = bus.MemWrite; s.regdst = bus.Reg_Dst;
      s.alusrc = bus.Alu_Src; s.jump = bus.Jump; s.aluop = bus.Alu_Op;
      s.add1 = bus.add1; s.rd1 = bus.rd1; s.rd2 = bus.rd2; s.sext = bus.signext;
      s.rt = bus.inst20_16; s.rd = bus.inst15_11; s.jaddr = bus.inst25_0;
      return s;
   endfunction

   function automatic logic model_hazard(input logic [4:0] rs, input logic [4:0] rt);
      return m.valid && m.memread && (m.rt != 5'd0) && (m.rt == rs || m.rt == rt);
   endfunction

   task automatic check_model();
      chk("valid", {63'd0, bus.valid_o}, {63'd0, m.valid});
      chk("EX", {58'd0, bus.EX}, {58'd0, m.alusrc, m.aluop, m.regdst});
      chk("M", {60'd0, bus.M}, {60'd0, m.jump, m.memwrite, m.memread, m.branch});
      chk("WB", {62'd0, bus.WB}, {62'd0, m.memtoreg, m.regwrite});
      chk("cnt", {48'd0, bubble_cnt_o}, 64'(mcnt));
      chk("add1", {32'd0, bus.salidAdd1}, {32'd0, m.add1});
      chk("rd1", {32'd0, bus.salidard1}, {32'd0, m.rd1});
      chk("rd2", {32'd0, bus.salidard2}, {32'd0, m.rd2});
      chk("sext", {32'd0, bus.salidasignext}, {32'd0, m.sext});
      chk("rt", {59'd0, bus.salidainst20_16}, {59'd0, m.rt});
      chk("rd", {59'd0, bus.salidainst15_11}, {59'd0, m.rd});
      chk("jaddr", {38'd0, bus.salidainst25_0}, {38'd0, m.jaddr});
   endtask

   vec_t vt[12];
   logic [1:0] sat_exp[5];

   initial begin
      vt[0]  = mk(0, 0, 1, 5'd1, 5'd5, 32'h04, 0, 1, 4'b0010, 2'b11, 6'b100100, 16'd0, 32'h04);
      vt[1]  = mk(0, 0, 0, 5'd5, 5'd9, 32'h08, 1, 0, 4'b0000, 2'b00, 6'b000000, 16'd1, 32'h04);
      vt[2]  = mk(0, 0, 0, 5'd5, 5'd9, 32'h08, 0, 1, 4'b0000, 2'b01, 6'b000100, 16'd1, 32'h08);
      vt[3]  = mk(0, 0, 1, 5'd2, 5'd0, 32'h0c, 0, 1, 4'b0010, 2'b11, 6'b100100, 16'd1, 32'h0c);
      vt[4]  = mk(0, 0, 0, 5'd0, 5'd0, 32'h10, 0, 1, 4'b0000, 2'b01, 6'b000100, 16'd1, 32'h10);
      vt[5]  = mk(0, 0, 1, 5'd1, 5'd5, 32'h14, 0, 1, 4'b0010, 2'b11, 6'b100100, 16'd1, 32'h14);
      vt[6]  = mk(0, 0, 0, 5'd6, 5'd7, 32'h18, 0, 1, 4'b0000, 2'b01, 6'b000100, 16'd1, 32'h18);
      vt[7]  = mk(0, 0, 1, 5'd3, 5'd5, 32'h1c, 0, 1, 4'b0010, 2'b11, 6'b100100, 16'd1, 32'h1c);
      vt[8]  = mk(1, 1, 0, 5'd5, 5'd2, 32'h20, 1, 1, 4'b0010, 2'b11, 6'b100100, 16'd1, 32'h1c);
      vt[9]  = mk(0, 1, 0, 5'd5, 5'd2, 32'h20, 1, 0, 4'b0000, 2'b00, 6'b000000, 16'd2, 32'h1c);
      vt[10] = mk(0, 1, 0, 5'd1, 5'd2, 32'h24, 0, 0, 4'b0000, 2'b00, 6'b000000, 16'd3, 32'h1c);
      vt[11] = mk(0, 0, 0, 5'd1, 5'd2, 32'h28, 0, 1, 4'b0000, 2'b01, 6'b000100, 16'd3, 32'h28);
      sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

      rst = 1'b1;
      clear_inputs();
      bus2.add1 = 32'h0; bus2.rd1 = 32'h0; bus2.rd2 = 32'h0; bus2.signext = 32'h0;
      bus2.inst25_21 = 5'd0; bus2.inst20_16 = 5'd0; bus2.inst15_11 = 5'd0; bus2.inst25_0 = 26'h0;
      bus2.RegWrite = 1'b0; bus2.MemtoReg = 1'b0; bus2.Branch = 1'b0; bus2.MemRead = 1'b0;
      bus2.MemWrite = 1'b0; bus2.Reg_Dst = 1'b0; bus2.Alu_Src = 1'b0; bus2.Jump = 1'b0;
      bus2.Alu_Op = 4'd0;
      stall2_i = 1'b0; flush2_i = 1'b0;
      #2;
      chk("rst_valid", {63'd0, bus.valid_o}, 64'd0);
      chk("rst_ctrl", {52'd0, bus.EX, bus.M, bus.WB}, 64'd0);
      chk("rst_cnt", {48'd0, bubble_cnt_o}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed vector table.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         clear_inputs();
         stall_i = vt[i].stall; flush_i = vt[i].flush;
         bus.inst25_21 = vt[i].rs; bus.inst20_16 = vt[i].rt; bus.add1 = vt[i].add1;
         bus.RegWrite = 1'b1; bus.Alu_Op = 4'b0010;
         bus.MemRead = vt[i].lw; bus.MemtoReg = vt[i].lw; bus.Alu_Src = vt[i].lw;
         #1;
         chk($sformatf("v%0d_hazard", i), {63'd0, hazard_o}, {63'd0, vt[i].exp_haz});
         chk($sformatf("v%0d_stall_o", i), {63'd0, stall_o}, {63'd0, vt[i].exp_haz | vt[i].stall});
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_valid", i), {63'd0, bus.valid_o}, {63'd0, vt[i].exp_valid});
         chk($sformatf("v%0d_M", i), {60'd0, bus.M}, {60'd0, vt[i].exp_m});
         chk($sformatf("v%0d_WB", i), {62'd0, bus.WB}, {62'd0, vt[i].exp_wb});
         chk($sformatf("v%0d_EX", i), {58'd0, bus.EX}, {58'd0, vt[i].exp_ex});
         chk($sformatf("v%0d_cnt", i), {48'd0, bubble_cnt_o}, {48'd0, vt[i].exp_cnt});
         chk($sformatf("v%0d_add1", i), {32'd0, bus.salidAdd1}, {32'd0, vt[i].exp_add1});
      end

      // Asynchronous reset between edges, then a clean first load.
      @(negedge clk);
      clear_inputs();
      rst = 1'b1;
      #1;
      chk("midrst_valid", {63'd0, bus.valid_o}, 64'd0);
      chk("midrst_ctrl", {52'd0, bus.EX, bus.M, bus.WB}, 64'd0);
      chk("midrst_add1", {32'd0, bus.salidAdd1}, 64'd0);
      chk("midrst_cnt", {48'd0, bubble_cnt_o}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.add1 = 32'h4; bus.rd1 = 32'h11;
      @(posedge clk);
      #1;
      chk("relrst_add1", {32'd0, bus.salidAdd1}, 64'h4);
      chk("relrst_rd1", {32'd0, bus.salidard1}, 64'h11);
      chk("relrst_valid", {63'd0, bus.valid_o}, 64'd1);

      // Saturation on the 2-bit counter instance.
      @(negedge clk);
      flush2_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("sat%0d_cnt", i), {62'd0, bubble_cnt2_o}, {62'd0, sat_exp[i]});
      end
      @(negedge clk);
      flush2_i = 1'b0;

      // Random traffic against the model.
      clear_inputs();
      rst = 1'b1;
      #1;
      rst = 1'b0;
      m = '{default: '0};
      mcnt = 0;
      for (int c = 0; c < 400; c++) begin
         logic exp_haz;
         stage_t nxt;
         @(negedge clk);
         stall_i = ($urandom_range(0, 4) == 0);
         flush_i = ($urandom_range(0, 5) == 0);
         bus.add1 = $urandom; bus.rd1 = $urandom; bus.rd2 = $urandom; bus.signext = $urandom;
         bus.inst25_21 = 5'($urandom_range(0, 3));
         bus.inst20_16 = 5'($urandom_range(0, 3));
         bus.inst15_11 = 5'($urandom);
         bus.inst25_0 = 26'($urandom);
         bus.RegWrite = 1'($urandom); bus.MemtoReg = 1'($urandom); bus.Branch = 1'($urandom);
         bus.MemRead = 1'($urandom); bus.MemWrite = 1'($urandom); bus.Reg_Dst = 1'($urandom);
         bus.Alu_Src = 1'($urandom); bus.Jump = 1'($urandom); bus.Alu_Op = 4'($urandom);
         #1;
         exp_haz = model_hazard(bus.inst25_21, bus.inst20_16);
         chk("rnd_hazard", {63'd0, hazard_o}, {63'd0, exp_haz});
         chk("rnd_stall_o", {63'd0, stall_o}, {63'd0, exp_haz | stall_i});
         nxt = id_snapshot();
         @(posedge clk);
         if (!stall_i) begin
            if (flush_i || exp_haz) begin
               m.valid = 1'b0; m.regwrite = 1'b0; m.memtoreg = 1'b0; m.branch = 1'b0;
               m.memread = 1'b0; m.memwrite = 1'b0; m.regdst = 1'b0; m.alusrc = 1'b0;
               m.jump = 1'b0; m.aluop = 4'd0;
               if (mcnt < 65535) mcnt = mcnt + 1;
            end else begin
               m = nxt;
            end
         end
         #1;
         check_model();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/buffer_id_ex_hz.md
Name: buffer_id_ex_hz

Overview:
- Parametrised ID/EX pipeline register for the pipelined MIPS datapath.
- Adds a valid bit, downstream stall (hold), flush (bubble), and built-in load-use hazard detection with automatic bubble insertion.
- Counts inserted bubbles.
- Sits between decode/register-file/control and the EX stage; drives upstream PC/IF-ID hold.

Parameters:
DATA_W, 32, width of PC+4, rd1, rd2, sign-extended immediate
REG_W, 5, register-address width
JADDR_W, 26, jump-target field width
ALUOP_W, 4, ALU-op control width
CNT_W, 16, bubble-counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
stall_i  in  1  EX stage cannot accept; hold register
flush_i  in  1  branch/jump taken; insert bubble
add1  in  DATA_W  PC+4 from ID
rd1  in  DATA_W  register-file read 1
rd2  in  DATA_W  register-file read 2
signext  in  DATA_W  sign-extended immediate
inst25_21  in  REG_W  rs field
inst20_16  in  REG_W  rt field
inst15_11  in  REG_W  rd field
inst25_0  in  JADDR_W  jump target
RegWrite, MemtoReg, Branch, MemRead, MemWrite, Reg_Dst, Alu_Src, Jump  in  1 each  control
Alu_Op  in  ALUOP_W  ALU control
EX  out  ALUOP_W+2  {Alu_Src, Alu_Op, Reg_Dst}
M  out  4  {Jump, MemWrite, MemRead, Branch}
WB  out  2  {MemtoReg, RegWrite}
valid_o  out  1  stage holds a real instruction
salidAdd1, salidard1, salidard2, salidasignext  out  DATA_W  registered data
salidainst20_16, salidainst15_11  out  REG_W  registered fields
salidainst25_0  out  JADDR_W  registered jump field
hazard_o  out  1  load-use hazard detected (combinational)
stall_o  out  1  hold PC and IF/ID = hazard_o | stall_i
bubble_cnt_o  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset: on rst high, immediately (async) clear all registered outputs.
  - Cleared: EX, M, WB, data fields, valid_o, bubble_cnt_o.
  - Releases cleanly mid-stream; first edge after release behaves as a normal load.
- hazard_o = valid_o & M[1] (registered MemRead) & (salidainst20_16 != 0) & (salidainst20_16 == inst25_21 | salidainst20_16 == inst20_16). Purely combinational, no latency.
- Per rising edge, priority order:
  1. stall_i=1: hold every register, including valid_o. Counter unchanged. Beats flush_i and hazard.
  2. flush_i=1 or hazard_o=1: bubble.
     - EX, M, WB and valid_o are set to 0.
     - Data fields hold their previous values (don't-care once valid_o=0).
     - bubble_cnt_o increments by 1; flush and hazard together still count 1.
  3. Otherwise, load: all fields capture inputs with 1-cycle latency, and valid_o=1.
- Bubble counter saturates at 2^CNT_W-1 and does not wrap.
- Upstream holding is the responsibility of upstream blocks, driven by stall_o. While a hazard is present the same ID instruction is re-presented next cycle. Hazard clears because the bubble has valid_o=0.
- Control packing bit order is fixed as listed under Ports; downstream stages index M[0]=Branch, M[1]=MemRead, M[2]=MemWrite, M[3]=Jump, WB[0]=RegWrite, WB[1]=MemtoReg, EX[0]=Reg_Dst, EX[ALUOP_W+1]=Alu_Src.
- Blocking vs non-blocking: all sequential updates non-blocking.

Decomposition:
- Shared package: field-position constants (M_BRANCH=0, M_MEMREAD=1, M_MEMWRITE=2, M_JUMP=3, WB_REGWRITE=0, WB_MEMTOREG=1, EX_REGDST=0), and widths EX_W=ALUOP_W+2, M_W=4, WB_W=2.
- One sub-module: hazard_load_use, a combinational comparator producing hazard_o.
- The register, priority mux and counter remain in the top module.

Test Plan:
- Reset mid-operation: load values, then assert rst between edges → all outputs 0 immediately, valid_o=0. Deassert, load add1=32'h4, rd1=32'h11 → next edge salidAdd1=4, salidard1=32'h11, valid_o=1.
- Normal load: RegWrite=1, MemtoReg=1, MemRead=1, Alu_Src=1, Alu_Op=4'b0010, Jump=0 → after one edge WB=2'b11, M=4'b0010, EX=6'b100100.
- Load-use: lw registered with salidainst20_16=5, M[1]=1, valid_o=1. Next ID inst25_21=5 → hazard_o=1, stall_o=1. After the edge M=0, WB=0, EX=0, valid_o=0, bubble_cnt_o=1, hazard_o=0. Same case with rt=0, or inst25_21=6 and inst20_16=7 → hazard_o=0.
- Stall priority: stall_i=1 with flush_i=1 and new inputs → all outputs unchanged, bubble_cnt_o unchanged, stall_o=1. Release stall with flush_i=1 → bubble, counter +1.
- Flush plus hazard in the same cycle → a single bubble, counter +1 (not +2).
- Saturation with CNT_W=2: force 5 bubbles → bubble_cnt_o reads 1, 2, 3, 3, 3.
